// File: rtl/lms_filter_n_if.sv
// Sample/result handshake and coefficient access port of the LMS filter.
// Widths track the filter parameters; keep both instances parameterised alike.
interface lms_filter_n_if #(
  parameter int TAPS        = 7,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 17,
  parameter int MU_SIZE     = 16
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [SAMPLE_SIZE-1:0] u_in;
  logic signed [SAMPLE_SIZE-1:0] d_in;
  logic signed [MU_SIZE-1:0]     mu_in;
  logic                          adapt_en;
  logic                          out_valid;
  logic signed [SAMPLE_SIZE-1:0] y_out;
  logic signed [SAMPLE_SIZE-1:0] e_out;
  logic                          coef_wr_en;
  logic [ADDR_W-1:0]             coef_addr;
  logic signed [COEFF_SIZE-1:0]  coef_wr_data;
  logic signed [COEFF_SIZE-1:0]  coef_rd_data;

  modport master (
    output in_valid, u_in, d_in, mu_in, adapt_en, coef_wr_en, coef_addr, coef_wr_data,
    input  in_ready, out_valid, y_out, e_out, coef_rd_data
  );

  modport slave (
    input  in_valid, u_in, d_in, mu_in, adapt_en, coef_wr_en, coef_addr, coef_wr_data,
    output in_ready, out_valid, y_out, e_out, coef_rd_data
  );
endinterface

// File: rtl/lms_filter_n.sv
// TAPS-tap LMS adaptive FIR with one shared multiplier: MAC over the delay line,
// error against the desired sample, then optional sign-correct coefficient update.
module lms_filter_n #(
  parameter int TAPS        = 7,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 17,
  parameter int MU_SIZE     = 16
) (
  input logic clk,
  input logic rst,
  lms_filter_n_if.slave bus
);
  localparam int S      = SAMPLE_SIZE;
  localparam int C      = COEFF_SIZE;
  localparam int M      = MU_SIZE;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int ADDR_X = ADDR_W + 1;
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int ACC_W  = S + C + $clog2(TAPS);
  localparam int ACC_X  = ACC_W + 1;
  localparam int PRD_W  = S + C;
  localparam int EM_W   = S + M;
  localparam int EMX    = S + M + 1;
  localparam int PW     = 2 * S;
  localparam int CX     = C + 1;

  localparam logic signed [S-1:0]     S_MAX  = {1'b0, {(S-1){1'b1}}};
  localparam logic signed [S-1:0]     S_MIN  = {1'b1, {(S-1){1'b0}}};
  localparam logic signed [C-1:0]     C_MAX  = {1'b0, {(C-1){1'b1}}};
  localparam logic signed [C-1:0]     C_MIN  = {1'b1, {(C-1){1'b0}}};
  localparam logic signed [ACC_W:0]   Y_RND  = ACC_X'(1) << (C - 3);
  localparam logic signed [EMX-1:0]   G_RND  = EMX'(1) << (M - 2);
  localparam logic [CNT_W-1:0]        LAST   = CNT_W'(TAPS);
  localparam logic [ADDR_W:0]         TAPS_L = ADDR_X'(TAPS);

  typedef enum logic [2:0] {IDLE, MAC, ERR, MU, UPD} state_t;

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [S-1:0]      u_reg [TAPS];
  logic signed [C-1:0]      w_reg [TAPS];
  logic signed [S-1:0]      d_reg;
  logic signed [M-1:0]      mu_reg;
  logic                     adapt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [PRD_W-1:0]  prod_reg;
  logic signed [S-1:0]      g_reg;
  logic signed [PW-1:0]     p_reg;
  logic signed [S-1:0]      y_out_reg;
  logic signed [S-1:0]      e_out_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;

  logic [CNT_W-1:0]         cnt_m1;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        prev_idx;
  logic                     addr_ok;
  logic signed [PRD_W-1:0]  mac_prod;
  logic signed [PW-1:0]     upd_prod;
  logic signed [ACC_W:0]    acc_rnd;
  logic signed [ACC_W:0]    acc_sh;
  logic signed [S-1:0]      y_next;
  logic [S:0]               diff;
  logic signed [S-1:0]      e_next;
  logic signed [EM_W-1:0]   em;
  logic signed [EMX-1:0]    em_rnd;
  logic signed [EMX-1:0]    em_sh;
  logic signed [S-1:0]      g_next;
  logic signed [C-1:0]      dw;
  logic signed [CX-1:0]     w_sum;
  logic signed [C-1:0]      w_next;

  assign cnt_m1   = cnt_reg - CNT_W'(1);
  assign idx      = cnt_reg[ADDR_W-1:0];
  assign prev_idx = cnt_m1[ADDR_W-1:0];
  assign addr_ok  = {1'b0, bus.coef_addr} < TAPS_L;
  assign mac_prod = PRD_W'(u_reg[idx]) * PRD_W'(w_reg[idx]);
  assign upd_prod = PW'(g_reg) * PW'(u_reg[idx]);

  always_comb begin
    acc_rnd = ACC_X'(acc_reg) + Y_RND;
    acc_sh  = acc_rnd >>> (C - 2);
    if (acc_sh[ACC_W:S-1] == {(ACC_X-S+1){acc_sh[ACC_W]}}) y_next = acc_sh[S-1:0];
    else                                                     y_next = acc_sh[ACC_W] ? S_MIN : S_MAX;
    diff = {d_reg[S-1], d_reg} - {y_next[S-1], y_next};
    if (diff[S] == diff[S-1]) e_next = diff[S-1:0];
    else                      e_next = diff[S] ? S_MIN : S_MAX;
    em     = EM_W'(e_out_reg) * EM_W'(mu_reg);
    em_rnd = EMX'(em) + G_RND;
    em_sh  = em_rnd >>> (M - 1);
    if (em_sh[EMX-1:S-1] == {(EMX-S+1){em_sh[EMX-1]}}) g_next = em_sh[S-1:0];
    else                                                g_next = em_sh[EMX-1] ? S_MIN : S_MAX;
    w_sum = CX'(w_reg[prev_idx]) + CX'(dw);
    if (w_sum[C] == w_sum[C-1]) w_next = w_sum[C-1:0];
    else                        w_next = w_sum[C] ? C_MIN : C_MAX;
  end

  // The update product only needs rescaling when it is wider than a coefficient.
  generate
    if (C < 2 * S) begin : g_round
      localparam int PX = PW + 1;
      localparam logic signed [PX-1:0] P_RND = PX'(1) << (2 * S - C - 1);
      logic signed [PX-1:0] p_rnd;
      logic signed [PX-1:0] p_sh;
      always_comb begin
        p_rnd = PX'(p_reg) + P_RND;
        p_sh  = p_rnd >>> (2 * S - C);
        if (p_sh[PX-1:C-1] == {(PX-C+1){p_sh[PX-1]}}) dw = p_sh[C-1:0];
        else                                          dw = p_sh[PX-1] ? C_MIN : C_MAX;
      end
    end else begin : g_exact
      assign dw = p_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      d_reg         <= '0;
      mu_reg        <= '0;
      adapt_reg     <= 1'b0;
      acc_reg       <= '0;
      prod_reg      <= '0;
      g_reg         <= '0;
      p_reg         <= '0;
      y_out_reg     <= '0;
      e_out_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        u_reg[k] <= '0;
        w_reg[k] <= '0;
      end
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (bus.coef_wr_en && addr_ok) w_reg[bus.coef_addr] <= bus.coef_wr_data;
          if (bus.in_valid && in_ready_reg) begin
            for (int k = TAPS - 1; k > 0; k--) u_reg[k] <= u_reg[k-1];
            u_reg[0]     <= bus.u_in;
            d_reg        <= bus.d_in;
            mu_reg       <= bus.mu_in;
            adapt_reg    <= bus.adapt_en;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MAC;
          end
        end
        // Product of tap j is registered in step j and accumulated in step j+1.
        MAC: begin
          if (cnt_reg != LAST) prod_reg <= mac_prod;
          if (cnt_reg != '0)   acc_reg  <= acc_reg + ACC_W'(prod_reg);
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= ERR;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ERR: begin
          y_out_reg     <= y_next;
          e_out_reg     <= e_next;
          out_valid_reg <= 1'b1;
          if (adapt_reg) begin
            state_reg <= MU;
          end else begin
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        MU: begin
          g_reg     <= g_next;
          cnt_reg   <= '0;
          state_reg <= UPD;
        end
        UPD: begin
          if (cnt_reg != LAST) p_reg <= upd_prod;
          if (cnt_reg != '0)   w_reg[prev_idx] <= w_next;
          if (cnt_reg == LAST) begin
            cnt_reg      <= '0;
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.y_out        = y_out_reg;
  assign bus.e_out        = e_out_reg;
  assign bus.coef_rd_data = addr_ok ? w_reg[bus.coef_addr] : '0;
endmodule

// File: tb/tb_lms_filter_n.sv
// Bench for lms_filter_n: directed cases plus random samples against an
// arithmetic model of the filter, output and coefficient update.
module tb_lms_filter_n;
  localparam int TAPS   = 7;
  localparam int S      = 16;
  localparam int C      = 17;
  localparam int M      = 16;
  localparam int ADDR_W = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lms_filter_n_if #(.TAPS(TAPS), .SAMPLE_SIZE(S), .COEFF_SIZE(C), .MU_SIZE(M)) bus ();

  lms_filter_n #(.TAPS(TAPS), .SAMPLE_SIZE(S), .COEFF_SIZE(C), .MU_SIZE(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_w [TAPS];
  longint m_u [TAPS];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -hi - 1;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  // Divide by 2^sh rounding half-up.
  function automatic longint rnd_shift(input longint x, input int sh);
    if (sh == 0) return x;
    return (x + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic longint rnd_s(input int w);
    longint v = longint'($urandom) & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
    return v;
  endfunction

  task automatic model(input longint u, input longint d, input longint mu, input bit ad,
                       output longint y, output longint e);
    longint acc = 0;
    longint g;
    for (int k = TAPS - 1; k > 0; k--) m_u[k] = m_u[k-1];
    m_u[0] = u;
    for (int j = 0; j < TAPS; j++) acc += m_u[j] * m_w[j];
    y = sat(rnd_shift(acc, C - 2), S);
    e = sat(d - y, S);
    if (ad) begin
      g = sat(rnd_shift(e * mu, M - 1), S);
      for (int j = 0; j < TAPS; j++)
        m_w[j] = sat(m_w[j] + sat(rnd_shift(g * m_u[j], 2 * S - C), C), C);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < TAPS; j++) begin
      m_w[j] = 0;
      m_u[j] = 0;
    end
  endtask

  task automatic wr_coef(input int a, input longint v);
    @(posedge clk); #1;
    bus.coef_wr_en   = 1'b1;
    bus.coef_addr    = ADDR_W'(a);
    bus.coef_wr_data = C'(v);
    @(posedge clk); #1;
    bus.coef_wr_en = 1'b0;
    m_w[a] = v;
  endtask

  task automatic check_coefs(input string tag);
    @(posedge clk); #1;
    for (int j = 0; j < TAPS; j++) begin
      bus.coef_addr = ADDR_W'(j);
      #1;
      check($sformatf("%s_w%0d", tag, j), bus.coef_rd_data, m_w[j]);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
  endtask

  task automatic send(input string tag, input longint u, input longint d, input longint mu, input bit ad);
    longint ey, ee;
    int t, c;
    @(posedge clk); #1;
    bus.u_in = S'(u); bus.d_in = S'(d); bus.mu_in = M'(mu); bus.adapt_en = ad;
    bus.in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 50);
    if (!bus.in_ready) begin
      check({tag, "_accept"}, bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    model(u, d, mu, ad, ey, ee);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.out_valid && c < 40);
    check({tag, "_lat"}, c, TAPS + 3);
    check({tag, "_y"}, bus.y_out, ey);
    check({tag, "_e"}, bus.e_out, ee);
    check({tag, "_rdy"}, bus.in_ready, !ad);
    $display("sample %s u=%0d d=%0d mu=%0d adapt=%0d -> y=%0d e=%0d", tag, u, d, mu, ad, bus.y_out, bus.e_out);
    @(negedge clk); c++;
    check({tag, "_pulse"}, bus.out_valid, 0);
    if (ad) begin
      while (!bus.in_ready && c < 80) begin @(negedge clk); c++; end
      check({tag, "_upd_lat"}, c, 2 * TAPS + 5);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ey, ee;
    longint exp_y [$];
    longint exp_e [$];
    int acc_cyc [$];
    int cyc, n_acc, nres;

    bus.in_valid = 1'b0; bus.u_in = '0; bus.d_in = '0; bus.mu_in = '0; bus.adapt_en = 1'b0;
    bus.coef_wr_en = 1'b0; bus.coef_addr = '0; bus.coef_wr_data = '0;
    clear_model();

    // Reset state while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_e", bus.e_out, 0);
    check("rst_w0", bus.coef_rd_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", bus.in_ready, 1);

    wr_coef(0, 32768);
    send("pass", 1000, 3000, 0, 0);
    check("pass_y_const", bus.y_out, 1000);

    wr_coef(0, 0);
    wr_coef(1, 16384);
    send("delay1", 2000, 0, 0, 0);
    send("delay2", 4000, 0, 0, 0);
    check("delay_e_const", bus.e_out, -1000);

    wr_coef(0, 65535);
    wr_coef(1, 65535);
    send("sat1", 30000, -32768, 0, 0);
    send("sat2", 30000, -32768, 0, 0);
    check("sat_y_const", bus.y_out, 32767);

    reset_dut();
    send("adapt", 16384, 8192, 16384, 1);
    check_coefs("adapt");
    bus.coef_addr = '0; #1;
    check("adapt_w0_const", bus.coef_rd_data, 2048);

    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) wr_coef($urandom_range(0, TAPS - 1), rnd_s(C));
      send($sformatf("rnd%0d", i), rnd_s(S), rnd_s(S), rnd_s(M), 1'($urandom_range(0, 1)));
    end
    check_coefs("rnd");
    @(posedge clk); #1 bus.coef_addr = ADDR_W'(TAPS);
    #1 check("oob_read", bus.coef_rd_data, 0);

    // Back-to-back with in_valid held high; a write pulse lands mid-MAC.
    wr_coef(0, 1000);
    @(posedge clk); #1;
    bus.coef_addr = '0; bus.coef_wr_data = C'(12345);
    bus.u_in = S'(rnd_s(S)); bus.d_in = S'(rnd_s(S)); bus.adapt_en = 1'b0; bus.in_valid = 1'b1;
    cyc = 0; n_acc = 0; nres = 0;
    while (nres < 5 && cyc < 300) begin
      @(negedge clk); cyc++;
      bus.coef_wr_en = (n_acc == 1 && cyc == acc_cyc[0] + 3);
      if (bus.out_valid) begin
        if (exp_y.size() == 0) check("b2b_spurious", bus.out_valid, 0);
        else begin
          ey = exp_y.pop_front(); ee = exp_e.pop_front();
          check($sformatf("b2b%0d_y", nres), bus.y_out, ey);
          check($sformatf("b2b%0d_e", nres), bus.e_out, ee);
          $display("sample b2b%0d -> y=%0d e=%0d", nres, bus.y_out, bus.e_out);
        end
        nres++;
      end
      if (bus.in_ready && n_acc < 5) begin
        model(longint'(bus.u_in), longint'(bus.d_in), 0, 1'b0, ey, ee);
        exp_y.push_back(ey); exp_e.push_back(ee);
        acc_cyc.push_back(cyc);
        n_acc++;
        @(posedge clk); #1;
        if (n_acc == 5) bus.in_valid = 1'b0;
        else begin
          bus.u_in = S'(rnd_s(S)); bus.d_in = S'(rnd_s(S));
        end
      end
    end
    bus.coef_wr_en = 1'b0;
    check("b2b_results", nres, 5);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], TAPS + 3);
    check_coefs("b2b");

    // Reset during UPD of an adapting sample.
    wr_coef(0, 5000);
    @(posedge clk); #1;
    bus.u_in = S'(1234); bus.d_in = S'(-777); bus.mu_in = M'(16384); bus.adapt_en = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("rstupd_accept", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rstupd_valid", bus.out_valid, 0);
    check("rstupd_y", bus.y_out, 0);
    check("rstupd_e", bus.e_out, 0);
    check("rstupd_ready", bus.in_ready, 0);
    clear_model();
    check_coefs("rstupd");
    #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstupd_ready_after", bus.in_ready, 1);
    wr_coef(1, 32768);
    wr_coef(6, 32768);
    send("ucleared", 500, 100, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lms_filter_n.md
# lms_filter_n

Parametrised, handshaked successor of the fixed 7-tap LMS adaptive filter. It runs a TAPS-tap time-multiplexed FIR with one shared multiply-accumulate, forms the error against a desired sample, and optionally updates all coefficients by sign-correct LMS. A valid/ready handshake replaces the internal sample-rate clock dividers. It adds an adaptation freeze, plus coefficient load and readback for preset and debug. It sits between the audio sample source and the error/output consumer in the adaptive-filtering chain.

## Interface
- TAPS, 7: number of taps, 2..64; delay line holds TAPS samples, newest at index 0.
- SAMPLE_SIZE, 16: signed sample width S, S-1 fractional bits.
- COEFF_SIZE, 17: signed coefficient width C, C-2 fractional bits, range [-2,2); constraint 3 <= C <= 2S.
- MU_SIZE, 16: signed step-size width M, M-1 fractional bits.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  u_in/d_in/mu_in/adapt_en valid.
- in_ready  out  1  high only in IDLE.
- u_in  in  S  reference sample.
- d_in  in  S  desired sample.
- mu_in  in  M  step size, sampled at handshake.
- adapt_en  in  1  1 = update coefficients for this sample, sampled at handshake.
- out_valid  out  1  one-cycle pulse; y_out/e_out valid.
- y_out  out  S  filter output, held until next pulse.
- e_out  out  S  error d - y, held until next pulse.
- coef_wr_en  in  1  coefficient write, honoured only in IDLE.
- coef_addr  in  clog2(TAPS)  write/read index.
- coef_wr_data  in  C  write data.
- coef_rd_data  out  C  combinational w[coef_addr]; out-of-range index reads 0.

## Operation
- Reset: w[], u[], accumulator, y_out, e_out = 0; out_valid = 0; in_ready = 0 while rst high, state IDLE after. Reset asserted in any state aborts the sample, with no partial coefficient write kept beyond the last completed edge, and clears everything.
- Handshake: accept on an edge with in_valid & in_ready. At that edge: u[k] <= u[k-1], u[0] <= u_in; latch d_in, mu_in, adapt_en.
- States: IDLE -> MAC (TAPS+1 cycles) -> ERR (1) -> MU (1, only if adapt latched) -> UPD (TAPS+1) -> IDLE. Without adaptation, ERR -> IDLE.
- MAC: cycle j (0..TAPS-1) registers the product u[j]*w[j] as a full S+C product. The next cycle adds it to the accumulator, which has width S+C+clog2(TAPS). The accumulator is cleared at handshake.
- ERR:
  - y_q = sat_S((acc + 2^(C-3)) >>> (C-2)).
  - e = sat_S(d - y_q), computed in S+1 bits.
  - y_out, e_out, out_valid registered at the end of ERR.
- MU: g = sat_S((e*mu + 2^(M-2)) >>> (M-1)).
- UPD:
  - Cycle j registers p = g*u[j].
  - Next cycle: w[j] <= sat_C(w[j] + sat_C((p + 2^(2S-C-1)) >>> (2S-C))).
  - When C = 2S, no rounding term.
- Saturation: clamp to [-2^(W-1), 2^(W-1)-1]. All shifts are arithmetic; rounding is half-up.
- Coefficient write in IDLE, same edge as a handshake: the write applies, and the new value is used by MAC. Writes outside IDLE are dropped.
- in_valid is ignored outside IDLE; no input buffering.

## Timing
- Accepting edge = cycle 0.
- out_valid is high in cycle TAPS+3 (10 for default), one cycle wide.
- in_ready rises:
  - Adaptation off: cycle TAPS+3. Back-to-back throughput is one sample per TAPS+3 cycles.
  - Adaptation on: cycle 2*TAPS+5 (19 for default).
- All UPD writes complete before in_ready rises, so the next sample sees the updated w.
- coef_rd_data follows w with zero-cycle latency.

## Test plan
- Passthrough: load w[0]=32768 (1.0), others 0, adapt_en=0, u=1000, d=3000. Required: out_valid at cycle 10 with y_out=1000, e_out=2000; in_ready high at cycle 10.
- Delay tap: w[1]=16384 (0.5), others 0. Send u=2000 then u=4000, d=0, adapt off. Required: second result y_out=1000, e_out=-1000.
- Saturation: w[0]=w[1]=65535, u=30000 twice, d=-32768. Required: second result y_out=32767, e_out=-32768.
- Adaptation: w=0, mu=16384, u=16384, d=8192, adapt_en=1. Required:
  - y_out=0, e_out=8192.
  - in_ready rises at cycle 19.
  - coef_rd_data[0]=2048, w[1..6]=0.
- Freeze and back-to-back: in_valid held high, adapt_en=0, 5 samples. Required: accepts at cycles 0,10,20,30,40; coefficients unchanged; coef_wr_en pulsed mid-MAC is ignored.
- Reset mid-UPD: assert rst at cycle 14 of an adapting sample. Required: next cycle out_valid=0, y_out=e_out=0, all w and u read 0, and in_ready=1 after rst drops.
